// File: rtl/divmmc_if.sv
//------------------------------------------------------------------------------
// Module      : divmmc_if
// Description : CPU-bus, memory-control and SD/SPI signal bundle for divmmc.
//               The master side is the CPU/board, the slave side is divmmc.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface divmmc_if;
    logic        ce;
    logic        enable;
    logic        mreq;
    logic        iorq;
    logic        m1;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        qEn;
    logic        divMap;
    logic        divRam;
    logic [3:0]  divPage;
    logic        spiCs;
    logic        spiCk;
    logic        spiDo;
    logic        spiDi;
    logic        busy;

    modport master (
        output ce, enable, mreq, iorq, m1, rd, wr, a, d, spiDi,
        input  q, qEn, divMap, divRam, divPage, spiCs, spiCk, spiDo, busy
    );

    modport slave (
        input  ce, enable, mreq, iorq, m1, rd, wr, a, d, spiDi,
        output q, qEn, divMap, divRam, divPage, spiCs, spiCk, spiDo, busy
    );
endinterface

`default_nettype wire

// File: rtl/divmmc.sv
//------------------------------------------------------------------------------
// Module      : divmmc
// Description : DivMMC control stage: E3h/E7h/EBh port decode, automap on
//               opcode fetches, and a byte-wide mode-0 SPI master for the SD.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module divmmc #(
    parameter int DIV = 1
) (
    input  logic      clock,
    input  logic      reset,
    divmmc_if.slave   bus
);

    localparam logic [7:0] c_PORT_E3 = 8'hE3;
    localparam logic [7:0] c_PORT_E7 = 8'hE7;
    localparam logic [7:0] c_PORT_EB = 8'hEB;
    localparam int         c_CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_DIV_LAST = c_CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } spi_state_t;

    // I/O strobe decode (edge-detected against the previous ce sample)
    logic w_ioWrLvl, w_ioRdLvl, w_ioWr, w_ioRd;
    logic w_wrE3, w_wrE7, w_wrEB, w_rdEB;
    logic ioWrPrev_q, ioRdPrev_q;

    assign w_ioWrLvl = !bus.iorq && !bus.wr;
    assign w_ioRdLvl = !bus.iorq && !bus.rd;
    assign w_ioWr    = bus.ce && w_ioWrLvl && !ioWrPrev_q;
    assign w_ioRd    = bus.ce && w_ioRdLvl && !ioRdPrev_q;
    assign w_wrE3    = w_ioWr && (bus.a[7:0] == c_PORT_E3);
    assign w_wrE7    = w_ioWr && (bus.a[7:0] == c_PORT_E7);
    assign w_wrEB    = w_ioWr && (bus.a[7:0] == c_PORT_EB);
    assign w_rdEB    = w_ioRd && (bus.a[7:0] == c_PORT_EB);

    // Remember the strobe levels seen at the last ce so each I/O cycle fires once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ioWrPrev_q <= 1'b0;
            ioRdPrev_q <= 1'b0;
        end else if (bus.ce) begin
            ioWrPrev_q <= w_ioWrLvl;
            ioRdPrev_q <= w_ioRdLvl;
        end
    end

    // Control registers written through E3h and E7h
    logic       conmem_q, mapram_q, spiCs_q;
    logic [3:0] page_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conmem_q <= 1'b0;
            mapram_q <= 1'b0;
            page_q   <= 4'h0;
            spiCs_q  <= 1'b1;
        end else begin
            if (w_wrE3) begin
                conmem_q <= bus.d[7];
                mapram_q <= mapram_q | bus.d[6];   // sticky until reset
                page_q   <= bus.d[3:0];
            end
            if (w_wrE7) begin
                spiCs_q <= bus.d[0];
            end
        end
    end

    // Automap address classification for M1 fetches
    logic w_m1Fetch, w_delayAddr, w_instAddr, w_unmapAddr;
    logic automap_q, mapPend_q, unmapPend_q;

    assign w_m1Fetch   = !bus.m1 && !bus.mreq;
    assign w_delayAddr = bus.a inside {16'h0000, 16'h0008, 16'h0038,
                                      16'h0066, 16'h04C6, 16'h0562};
    assign w_instAddr  = (bus.a[15:8] == 8'h3D);
    assign w_unmapAddr = (bus.a[15:3] == 13'h03FF);

    // Automap: pend on M1, resolve on the first ce with m1 high, unmap wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            automap_q   <= 1'b0;
            mapPend_q   <= 1'b0;
            unmapPend_q <= 1'b0;
        end else if (bus.ce) begin
            if (!bus.enable) begin
                automap_q   <= 1'b0;
                mapPend_q   <= 1'b0;
                unmapPend_q <= 1'b0;
            end else if (w_m1Fetch) begin
                if (w_delayAddr) mapPend_q   <= 1'b1;
                if (w_unmapAddr) unmapPend_q <= 1'b1;
                if (w_instAddr)  automap_q   <= 1'b1;
            end else if (bus.m1) begin
                if (unmapPend_q)    automap_q <= 1'b0;
                else if (mapPend_q) automap_q <= 1'b1;
                mapPend_q   <= 1'b0;
                unmapPend_q <= 1'b0;
            end
        end
    end

    // SPI master state and datapath
    spi_state_t      state_q, state_d;
    logic [c_CW-1:0] divCnt_q, divCnt_d;
    logic [2:0]      bitCnt_q, bitCnt_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rxSh_q, rxSh_d;
    logic [7:0]      rx_q, rx_d;
    logic            w_spiStart;
    logic [7:0]      w_startByte;

    // A transfer starts only from idle; EBh accesses while busy are dropped
    assign w_spiStart  = (w_wrEB || w_rdEB) && (state_q == S_IDLE);
    assign w_startByte = w_wrEB ? bus.d : 8'hFF;

    // SPI next-state: DIV clocks low (MOSI valid), DIV clocks high (MISO sampled)
    always_comb begin
        state_d  = state_q;
        divCnt_d = divCnt_q;
        bitCnt_d = bitCnt_q;
        tx_d     = tx_q;
        rxSh_d   = rxSh_q;
        rx_d     = rx_q;
        case (state_q)
            S_IDLE: begin
                if (w_spiStart) begin
                    state_d  = S_LOW;
                    tx_d     = w_startByte;
                    divCnt_d = '0;
                    bitCnt_d = 3'd0;
                end
            end
            S_LOW: begin
                if (divCnt_q == c_DIV_LAST) begin
                    divCnt_d = '0;
                    state_d  = S_HIGH;
                    rxSh_d   = {rxSh_q[6:0], bus.spiDi};
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (divCnt_q == c_DIV_LAST) begin
                    divCnt_d = '0;
                    tx_d     = {tx_q[6:0], 1'b1};
                    if (bitCnt_q == 3'd7) begin
                        state_d = S_IDLE;
                        rx_d    = rxSh_q;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                        state_d  = S_LOW;
                    end
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SPI state register; reset aborts any transfer and forgets the last byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            divCnt_q <= '0;
            bitCnt_q <= 3'd0;
            tx_q     <= 8'hFF;
            rxSh_q   <= 8'hFF;
            rx_q     <= 8'hFF;
        end else begin
            state_q  <= state_d;
            divCnt_q <= divCnt_d;
            bitCnt_q <= bitCnt_d;
            tx_q     <= tx_d;
            rxSh_q   <= rxSh_d;
            rx_q     <= rx_d;
        end
    end

    // Read data: capture the previous byte at the EBh read strobe, hold until the read ends
    logic [7:0] q_q;
    logic       qEn_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q   <= 8'hFF;
            qEn_q <= 1'b0;
        end else if (w_rdEB) begin
            q_q   <= rx_q;
            qEn_q <= 1'b1;
        end else if (bus.ce && !(w_ioRdLvl && (bus.a[7:0] == c_PORT_EB))) begin
            qEn_q <= 1'b0;
        end
    end

    assign bus.q       = q_q;
    assign bus.qEn     = qEn_q;
    assign bus.divMap  = conmem_q | automap_q;
    assign bus.divRam  = mapram_q & !conmem_q;
    assign bus.divPage = page_q;
    assign bus.spiCs   = spiCs_q;
    assign bus.spiCk   = (state_q == S_HIGH);
    assign bus.spiDo   = (state_q == S_IDLE) ? 1'b1 : tx_q[7];
    assign bus.busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_divmmc.sv
//------------------------------------------------------------------------------
// Module      : tb_divmmc
// Description : Self-checking bench for divmmc: directed scenarios followed by
//               randomized bus operations against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_divmmc;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    divmmc_if bus ();

    divmmc #(.DIV(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // MISO source: 0 = looped to MOSI, 1 = constant 0, 2 = constant 1
    int spi_mode = 0;
    assign bus.spiDi = (spi_mode == 0) ? bus.spiDo : ((spi_mode == 1) ? 1'b0 : 1'b1);

    // Bit capture on each SPI rising edge, and busy-clock counting
    logic mosi_q[$];
    int   busy_cnt = 0;
    logic prev_ck  = 1'b0;
    always @(negedge clock) begin
        if (bus.busy) busy_cnt++;
        if (bus.spiCk && !prev_ck) mosi_q.push_back(bus.spiDo);
        prev_ck = bus.spiCk;
    end

    // Behavioural model state
    logic       m_conmem, m_mapram, m_automap, m_mapP, m_unmapP, m_cs, m_busy;
    logic [3:0] m_page;
    logic [7:0] m_rx, m_tx;
    int         mon_start, busy_start;
    logic [15:0] delay_tab [6] = '{16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_conmem = 0; m_mapram = 0; m_automap = 0; m_mapP = 0; m_unmapP = 0;
        m_cs = 1; m_busy = 0; m_page = 0; m_rx = 8'hFF; m_tx = 8'hFF;
    endtask

    task automatic bus_idle();
        bus.ce = 1; bus.iorq = 1; bus.wr = 1; bus.rd = 1; bus.m1 = 1; bus.mreq = 1;
    endtask

    task automatic model_enable_gate();
        if (!bus.enable) begin m_automap = 0; m_mapP = 0; m_unmapP = 0; end
    endtask

    task automatic model_spi_start(input logic [7:0] b);
        if (!m_busy) begin
            m_busy = 1; m_tx = b;
            mon_start = mosi_q.size(); busy_start = busy_cnt;
        end
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        model_enable_gate();
        if (port == 8'hE3) begin
            m_conmem = data[7]; m_mapram = m_mapram | data[6]; m_page = data[3:0];
        end
        if (port == 8'hE7) m_cs = data[0];
        if (port == 8'hEB) model_spi_start(data);
        bus.a = {8'($urandom), port}; bus.d = data; bus.iorq = 0; bus.wr = 0;
        tick();
        tick();
        bus.iorq = 1; bus.wr = 1;
        tick();
    endtask

    task automatic io_read_eb();
        model_enable_gate();
        bus.a = {8'($urandom), 8'hEB}; bus.iorq = 0; bus.rd = 0;
        tick();
        check("qEn_during_read", bus.qEn, 1);
        check("q_read_eb", bus.q, m_rx);
        model_spi_start(8'hFF);
        tick();
        bus.iorq = 1; bus.rd = 1;
        tick();
        check("qEn_after_read", bus.qEn, 0);
    endtask

    function automatic logic is_delay(input logic [15:0] ad);
        foreach (delay_tab[i]) if (delay_tab[i] == ad) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m1_fetch(input logic [15:0] addr);
        model_enable_gate();
        if (bus.enable) begin
            if (is_delay(addr)) m_mapP = 1;
            if (addr >= 16'h1FF8 && addr <= 16'h1FFF) m_unmapP = 1;
            if (addr >= 16'h3D00 && addr <= 16'h3DFF) m_automap = 1;
        end
        bus.a = addr; bus.m1 = 0; bus.mreq = 0; bus.rd = 0;
        tick();
        check("divMap_in_m1", bus.divMap, m_conmem | m_automap);
        tick();
        bus.m1 = 1; bus.mreq = 1; bus.rd = 1;
        tick();
        if (bus.enable) begin
            if (m_unmapP) m_automap = 0;
            else if (m_mapP) m_automap = 1;
        end
        m_mapP = 0; m_unmapP = 0;
        check("divMap_after_m1", bus.divMap, m_conmem | m_automap);
    endtask

    function automatic logic [7:0] rx_for(input logic [7:0] b);
        return (spi_mode == 0) ? b : ((spi_mode == 1) ? 8'h00 : 8'hFF);
    endfunction

    task automatic wait_idle();
        int n = 0;
        logic [7:0] got = 8'h00;
        while (bus.busy && n < 100) begin tick(); n++; end
        check("busy_timeout", {15'd0, bus.busy}, 0);
        if (m_busy) begin
            check("mosi_bit_count", 16'(mosi_q.size() - mon_start), 8);
            for (int i = 0; i < 8; i++)
                if (mon_start + i < mosi_q.size()) got = {got[6:0], mosi_q[mon_start + i]};
            check("mosi_byte", got, m_tx);
            check("busy_clocks", 16'(busy_cnt - busy_start), 16);
            m_rx = rx_for(m_tx);
            m_busy = 0;
        end
        check("spiCk_idle", bus.spiCk, 0);
        check("spiDo_idle", bus.spiDo, 1);
    endtask

    task automatic check_outputs();
        check("divMap", bus.divMap, m_conmem | m_automap);
        check("divRam", bus.divRam, m_mapram & !m_conmem);
        check("divPage", bus.divPage, m_page);
        check("spiCs", bus.spiCs, m_cs);
    endtask

    task automatic junk_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ce = 0;
            bus.iorq = 1'($urandom); bus.wr = 1'($urandom); bus.rd = 1'($urandom);
            bus.m1 = 1'($urandom); bus.mreq = 1'($urandom);
            bus.a = 16'($urandom); bus.d = 8'($urandom);
            tick();
        end
        bus_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] addr;
        int op;
        bus_idle();
        bus.enable = 1; bus.a = 16'h0; bus.d = 8'h0;
        model_reset();
        tick(); tick();
        reset = 0;
        tick();

        // Reset state
        check_outputs();
        check("rst_spiCk", bus.spiCk, 0);
        check("rst_spiDo", bus.spiDo, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_qEn", bus.qEn, 0);
        check("rst_q", bus.q, 8'hFF);

        // E3h: conmem, sticky mapram, page
        io_write(8'hE3, 8'h80); check_outputs();
        io_write(8'hE3, 8'h43); check_outputs();
        check("divPage_3", bus.divPage, 4'h3);
        io_write(8'hE3, 8'h00); check_outputs();
        check("mapram_sticky", bus.divRam, 1);

        // Automap: delayed, unmap, instant, disabled
        m1_fetch(16'h0038);
        m1_fetch(16'h1FFB);
        m1_fetch(16'h3D2A);
        bus.enable = 0;
        m1_fetch(16'h0000);
        m1_fetch(16'h3D2A);
        bus.enable = 1;

        // SPI loopback transfer, then read back
        spi_mode = 0;
        io_write(8'hE7, 8'h00); check_outputs();
        io_write(8'hEB, 8'hA5);
        check("busy_started", bus.busy, 1);
        wait_idle();
        io_read_eb();
        wait_idle();

        // Writes and reads while busy are ignored
        io_write(8'hEB, 8'h3C);
        io_write(8'hEB, 8'h77);
        io_read_eb();
        wait_idle();
        io_read_eb();
        wait_idle();

        // Randomized operations
        for (int it = 0; it < 60; it++) begin
            junk_ticks($urandom_range(0, 3));
            bus.enable = ($urandom_range(0, 4) != 0);
            op = $urandom_range(0, 6);
            case (op)
                0: io_write(8'hE3, 8'($urandom));
                1: io_write(8'hE7, 8'($urandom));
                2, 3: begin
                    case ($urandom_range(0, 3))
                        0: addr = delay_tab[$urandom_range(0, 5)];
                        1: addr = 16'h1FF8 + 16'($urandom_range(0, 7));
                        2: addr = 16'h3D00 + 16'($urandom_range(0, 255));
                        default: addr = 16'($urandom);
                    endcase
                    m1_fetch(addr);
                end
                4, 5: begin
                    spi_mode = $urandom_range(0, 2);
                    io_write(8'hEB, 8'($urandom));
                    wait_idle();
                end
                default: begin
                    spi_mode = $urandom_range(0, 2);
                    io_read_eb();
                    wait_idle();
                end
            endcase
            check_outputs();
        end

        // Reset in the middle of a transfer
        bus.enable = 1;
        io_write(8'hE3, 8'h80);
        spi_mode = 0;
        io_write(8'hEB, 8'h3C);
        tick(); tick(); tick(); tick();
        reset = 1;
        #1;
        model_reset();
        check("abort_busy", bus.busy, 0);
        check("abort_spiCk", bus.spiCk, 0);
        check_outputs();
        tick();
        reset = 0;
        tick();
        io_read_eb();
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
